// File: rtl/sram_pkg.sv
// Shared types and constants for the single-port masked-write SRAM.
// Holds the init-sequencer state encoding and the supported read latencies.
package sram_pkg;

    typedef enum logic {
        INIT_CLEAR = 1'b0,
        INIT_IDLE  = 1'b1
    } init_state_e;

    localparam int READ_LAT_1 = 1;
    localparam int READ_LAT_2 = 2;

endpackage

// File: rtl/sram_init_seq.sv
// Init sequencer: after reset it walks a clear counter over addresses 0..WORDS-1,
// one per cycle, then parks in IDLE with ready raised until the next reset.
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int WORDS          = 22,
    parameter int ADDR_WIDTH     = 5,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output init_state_e           state,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  ready
);

    localparam init_state_e           RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT_CLEAR : INIT_IDLE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(WORDS - 1);

    // The counter stops at LAST_ADDR; the state change ends the sweep, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RESET_STATE;
            clear_addr <= '0;
            ready      <= (CLEAR_ON_RESET == 0);
        end else begin
            case (state)
                INIT_CLEAR: begin
                    if (clear_addr == LAST_ADDR) begin
                        state <= INIT_IDLE;
                        ready <= 1'b1;
                    end else begin
                        clear_addr <= clear_addr + 1'b1;
                    end
                end
                INIT_IDLE: ready <= 1'b1;
                default: begin
                    state <= RESET_STATE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_1rw_wmask.sv
// Single-port SRAM with per-lane write mask, 1- or 2-cycle read pipeline,
// out-of-range detection and an optional zero-fill sequence after reset.
module sram_1rw_wmask
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 5,
    parameter int WORDS          = 22,
    parameter int WMASK_WIDTH    = 8,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk0,
    input  logic                   rst0,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   dout0_valid,
    output logic                   ready0,
    output logic                   oob0
);

    localparam int                  LW      = DATA_WIDTH / WMASK_WIDTH;
    localparam int                  LAT     = (READ_LATENCY == READ_LAT_2) ? READ_LAT_2 : READ_LAT_1;
    localparam logic [ADDR_WIDTH:0] WORDS_W = (ADDR_WIDTH + 1)'(WORDS);

    logic [DATA_WIDTH-1:0] mem [WORDS];
    init_state_e           init_state;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic                  clear_en;
    logic                  accept;
    logic                  in_range;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] rd_word;

    sram_init_seq #(
        .WORDS          (WORDS),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_init_seq (
        .clk        (clk0),
        .rst        (rst0),
        .state      (init_state),
        .clear_addr (clear_addr),
        .ready      (ready0)
    );

    // Access handshake: an access is taken on a rising clk0 when csb0=0 and ready0=1;
    // any access presented while ready0=0 is ignored with no side effects.
    assign clear_en  = (init_state == INIT_CLEAR) && !rst0;
    assign accept    = !csb0 && ready0 && !rst0;
    assign in_range  = {1'b0, addr0} < WORDS_W;
    assign wr_accept = accept && !web0;
    assign rd_accept = accept && web0;
    assign rd_word   = in_range ? mem[addr0] : '0;

    // Storage has no reset so that reset leaves contents alone.
    always_ff @(posedge clk0) begin
        if (clear_en) begin
            mem[clear_addr] <= '0;
        end else if (wr_accept && in_range) begin
            for (int i = 0; i < WMASK_WIDTH; i++) begin
                if (wmask0[i]) mem[addr0][i*LW +: LW] <= din0[i*LW +: LW];
            end
        end
    end

    // An all-zero-mask write is a no-op and does not flag out-of-range.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) oob0 <= 1'b0;
        else      oob0 <= accept && !in_range && (web0 || (|wmask0));
    end

    if (LAT == READ_LAT_2) begin : g_lat2
        logic                  s_valid;
        logic [DATA_WIDTH-1:0] s_data;

        always_ff @(posedge clk0 or posedge rst0) begin
            if (rst0) begin
                s_valid     <= 1'b0;
                s_data      <= '0;
                dout0       <= '0;
                dout0_valid <= 1'b0;
            end else begin
                s_valid     <= rd_accept;
                dout0_valid <= s_valid;
                if (rd_accept) s_data <= rd_word;
                if (s_valid)   dout0  <= s_data;
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk0 or posedge rst0) begin
            if (rst0) begin
                dout0       <= '0;
                dout0_valid <= 1'b0;
            end else begin
                dout0_valid <= rd_accept;
                if (rd_accept) dout0 <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_sram_1rw_wmask.sv
// Directed bench: dut_a (1-cycle read, zero-fill on reset) and dut_b (2-cycle read,
// no zero-fill) exercised by a linear sequence of steps with hand-computed results.
module tb_sram_1rw_wmask;

    logic        clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    logic        rst_a, csb_a, web_a, dout_valid_a, ready_a, oob_a;
    logic [7:0]  wmask_a;
    logic [4:0]  addr_a;
    logic [63:0] din_a, dout_a;
    logic        rst_b, csb_b, web_b, dout_valid_b, ready_b, oob_b;
    logic [7:0]  wmask_b;
    logic [4:0]  addr_b;
    logic [63:0] din_b, dout_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_mem [22];

    sram_1rw_wmask #(
        .DATA_WIDTH(64), .ADDR_WIDTH(5), .WORDS(22), .WMASK_WIDTH(8),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk0(clk0), .rst0(rst_a), .csb0(csb_a), .web0(web_a), .wmask0(wmask_a),
        .addr0(addr_a), .din0(din_a), .dout0(dout_a), .dout0_valid(dout_valid_a),
        .ready0(ready_a), .oob0(oob_a)
    );

    sram_1rw_wmask #(
        .DATA_WIDTH(64), .ADDR_WIDTH(5), .WORDS(22), .WMASK_WIDTH(8),
        .READ_LATENCY(2), .CLEAR_ON_RESET(0)
    ) dut_b (
        .clk0(clk0), .rst0(rst_b), .csb0(csb_b), .web0(web_b), .wmask0(wmask_b),
        .addr0(addr_b), .din0(din_b), .dout0(dout_b), .dout0_valid(dout_valid_b),
        .ready0(ready_b), .oob0(oob_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic wr_a(input logic [4:0] addr, input logic [63:0] din,
                        input logic [7:0] mask, input logic exp_oob);
        addr_a = addr; din_a = din; wmask_a = mask; web_a = 1'b0; csb_a = 1'b0;
        tick();
        csb_a = 1'b1; web_a = 1'b1;
        check($sformatf("wr_oob_a%0d", addr), 64'(oob_a), 64'(exp_oob));
        check($sformatf("wr_novalid_a%0d", addr), 64'(dout_valid_a), 64'd0);
        if (addr < 5'd22) begin
            for (int i = 0; i < 8; i++)
                if (mask[i]) exp_mem[addr][i*8 +: 8] = din[i*8 +: 8];
        end
    endtask

    task automatic rd_a(input logic [4:0] addr, input logic [63:0] exp,
                        input logic exp_oob, input string tag);
        addr_a = addr; web_a = 1'b1; csb_a = 1'b0;
        tick();
        csb_a = 1'b1;
        check({tag, "_valid"}, 64'(dout_valid_a), 64'd1);
        check({tag, "_dout"}, dout_a, exp);
        check({tag, "_oob"}, 64'(oob_a), 64'(exp_oob));
    endtask

    task automatic wr_b(input logic [4:0] addr, input logic [63:0] din);
        addr_b = addr; din_b = din; wmask_b = 8'hFF; web_b = 1'b0; csb_b = 1'b0;
        tick();
        csb_b = 1'b1; web_b = 1'b1;
    endtask

    initial begin
        int cnt;
        logic spur;
        rst_a = 1'b1; csb_a = 1'b1; web_a = 1'b1; wmask_a = '0; addr_a = '0; din_a = '0;
        rst_b = 1'b1; csb_b = 1'b1; web_b = 1'b1; wmask_b = '0; addr_b = '0; din_b = '0;
        #2;
        check("rst_ready_a", 64'(ready_a), 64'd0);
        check("rst_dout_a", dout_a, 64'd0);
        check("rst_valid_a", 64'(dout_valid_a), 64'd0);
        check("rst_oob_a", 64'(oob_a), 64'd0);
        check("rst_ready_b", 64'(ready_b), 64'd1);
        check("rst_dout_b", dout_b, 64'd0);
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;
        check("rel_ready_a", 64'(ready_a), 64'd0);
        check("rel_ready_b", 64'(ready_b), 64'd1);

        // Zero-fill lasts exactly 22 cycles.
        cnt = 0;
        while (ready_a !== 1'b1 && cnt < 100) begin tick(); cnt++; end
        check("clear_cycles", 64'(cnt), 64'd22);
        for (int i = 0; i < 22; i++) exp_mem[i] = '0;
        rd_a(5'd21, 64'd0, 1'b0, "rd21_after_clear");

        // Lane masking on address 3.
        wr_a(5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        wr_a(5'd3, 64'h0, 8'h0F, 1'b0);
        rd_a(5'd3, 64'hFFFF_FFFF_0000_0000, 1'b0, "rd3_mask");
        tick();
        check("hold_valid", 64'(dout_valid_a), 64'd0);
        check("hold_dout", dout_a, 64'hFFFF_FFFF_0000_0000);
        wr_a(5'd5, 64'h0123_4567_89AB_CDEF, 8'h81, 1'b0);
        check("wr_keeps_dout", dout_a, 64'hFFFF_FFFF_0000_0000);
        rd_a(5'd5, 64'h0100_0000_0000_00EF, 1'b0, "rd5_m81");
        wr_a(5'd5, 64'hFEDC_BA98_7654_3210, 8'h3C, 1'b0);
        rd_a(5'd5, 64'h0100_BA98_7654_00EF, 1'b0, "rd5_m3c");

        // Back-to-back reads, one per cycle.
        addr_a = 5'd3; web_a = 1'b1; csb_a = 1'b0;
        tick();
        check("b2b_0_valid", 64'(dout_valid_a), 64'd1);
        check("b2b_0_dout", dout_a, 64'hFFFF_FFFF_0000_0000);
        addr_a = 5'd5;
        tick();
        csb_a = 1'b1;
        check("b2b_1_valid", 64'(dout_valid_a), 64'd1);
        check("b2b_1_dout", dout_a, 64'h0100_BA98_7654_00EF);

        // All-zero mask: no change, no oob.
        wr_a(5'd3, 64'h0, 8'h00, 1'b0);
        rd_a(5'd3, 64'hFFFF_FFFF_0000_0000, 1'b0, "rd3_zero_mask");
        wr_a(5'd21, 64'h5A5A_5A5A_5A5A_5A5A, 8'hAA, 1'b0);
        rd_a(5'd21, 64'h5A00_5A00_5A00_5A00, 1'b0, "rd21_mAA");
        wr_a(5'd15, 64'h1234, 8'hFF, 1'b0);

        // Out-of-range read and write.
        rd_a(5'd25, 64'd0, 1'b1, "rd25_oob");
        tick();
        check("oob_pulse_end_rd", 64'(oob_a), 64'd0);
        wr_a(5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        tick();
        check("oob_pulse_end_wr", 64'(oob_a), 64'd0);
        for (int i = 0; i < 22; i++) rd_a(5'(i), exp_mem[i], 1'b0, $sformatf("scan%0d", i));

        // Reset at clear count 10, then a write during clear must be dropped.
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_clear_ready", 64'(ready_a), 64'd0);
        rst_a = 1'b1;
        #1;
        check("mid_rst_dout", dout_a, 64'd0);
        check("mid_rst_ready", 64'(ready_a), 64'd0);
        tick();
        rst_a = 1'b0;
        cnt = 0; spur = 1'b0;
        while (ready_a !== 1'b1 && cnt < 100) begin
            if (cnt == 4) begin
                addr_a = 5'd2; din_a = 64'hDEAD_BEEF_0BAD_F00D; wmask_a = 8'hFF;
                web_a = 1'b0; csb_a = 1'b0;
            end else begin
                csb_a = 1'b1; web_a = 1'b1;
            end
            tick();
            cnt++;
            spur = spur | dout_valid_a;
        end
        csb_a = 1'b1; web_a = 1'b1;
        check("restart_cycles", 64'(cnt), 64'd22);
        check("restart_no_valid", 64'(spur), 64'd0);
        rd_a(5'd2, 64'd0, 1'b0, "rd2_dropped_wr");
        rd_a(5'd15, 64'd0, 1'b0, "rd15_recleared");
        rd_a(5'd21, 64'd0, 1'b0, "rd21_recleared");

        // dut_b: 2-cycle pipelined reads.
        wr_b(5'd0, 64'hA);
        wr_b(5'd1, 64'hB);
        wr_b(5'd2, 64'hC);
        addr_b = 5'd0; web_b = 1'b1; csb_b = 1'b0;
        tick();
        check("l2_e1_valid", 64'(dout_valid_b), 64'd0);
        addr_b = 5'd1;
        tick();
        check("l2_e2_valid", 64'(dout_valid_b), 64'd1);
        check("l2_e2_dout", dout_b, 64'hA);
        addr_b = 5'd2;
        tick();
        csb_b = 1'b1;
        check("l2_e3_valid", 64'(dout_valid_b), 64'd1);
        check("l2_e3_dout", dout_b, 64'hB);
        tick();
        check("l2_e4_valid", 64'(dout_valid_b), 64'd1);
        check("l2_e4_dout", dout_b, 64'hC);
        tick();
        check("l2_e5_valid", 64'(dout_valid_b), 64'd0);
        check("l2_e5_hold", dout_b, 64'hC);

        addr_b = 5'd25; csb_b = 1'b0;
        tick();
        csb_b = 1'b1;
        check("l2_oob_pulse", 64'(oob_b), 64'd1);
        check("l2_oob_novalid", 64'(dout_valid_b), 64'd0);
        tick();
        check("l2_oob_end", 64'(oob_b), 64'd0);
        check("l2_oob_valid", 64'(dout_valid_b), 64'd1);
        check("l2_oob_dout", dout_b, 64'd0);

        // Reset with a read in flight.
        addr_b = 5'd2; csb_b = 1'b0;
        tick();
        csb_b = 1'b1;
        tick();
        check("l2_pre_valid", 64'(dout_valid_b), 64'd1);
        check("l2_pre_dout", dout_b, 64'hC);
        addr_b = 5'd1; csb_b = 1'b0;
        tick();
        csb_b = 1'b1;
        #1;
        rst_b = 1'b1;
        #1;
        check("flight_rst_dout", dout_b, 64'd0);
        check("flight_rst_valid", 64'(dout_valid_b), 64'd0);
        check("flight_rst_ready", 64'(ready_b), 64'd1);
        tick();
        check("flight_e1_valid", 64'(dout_valid_b), 64'd0);
        rst_b = 1'b0;
        tick();
        check("flight_e2_valid", 64'(dout_valid_b), 64'd0);
        tick();
        check("flight_e3_valid", 64'(dout_valid_b), 64'd0);
        check("flight_e3_dout", dout_b, 64'd0);

        // Reset leaves contents of dut_b intact.
        addr_b = 5'd0; csb_b = 1'b0;
        tick();
        csb_b = 1'b1;
        tick();
        check("post_rst_valid", 64'(dout_valid_b), 64'd1);
        check("post_rst_dout", dout_b, 64'hA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
